// File: rtl/pipe_skid.sv
// pipe_skid: two-entry elastic pipeline register (skid buffer).
// A main entry drives the output and a skid entry catches the one payload that
// can arrive while downstream stalls. in_ready is taken from registered state
// only, so no combinational ready path runs from the outputs back to the inputs.
// Optional feature: define PIPE_SKID_STALL_CNT_EN to build the saturating
// backpressure counter. Without it, stall_cnt is tied to zero.
module pipe_skid #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  stall_cnt
);

  // The state also encodes the valid bits: main_v = (state != EMPTY),
  // skid_v = (state == FULL).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main_d;
  logic [WIDTH-1:0] r_skid_d;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid_in;

  assign in_ready   = (r_state != FULL);
  assign out_valid  = (r_state != EMPTY);
  assign out_data   = r_main_d;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // State register; reset empties both entries at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and data-load strobes; flush overrides every transition and
  // suppresses all loads, so a payload accepted in the flush cycle is dropped.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid_in   = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_load_main_in = 1'b1;
            w_state_nxt    = HALF;
          end
        end
        HALF: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_load_skid_in = 1'b1;
            w_state_nxt    = FULL;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = HALF;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  // Payload registers change only on a load; flush leaves their contents alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_d <= '0;
      r_skid_d <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_d <= in_data;
      end else if (w_load_main_skid) begin
        r_main_d <= r_skid_d;
      end
      if (w_load_skid_in) begin
        r_skid_d <= in_data;
      end
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CNTW-1:0] r_stall_cnt;

  // Count cycles where a payload waits on downstream; saturate at all ones.
  // Only reset clears the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != {CNTW{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNTW'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid.sv
// tb_pipe_skid: randomized and directed stimulus for pipe_skid, checked every
// cycle against a queue-based reference model of a two-deep FIFO.
// The stall counter is expected only when PIPE_SKID_STALL_CNT_EN is defined.
module tb_pipe_skid;

  localparam int WIDTH = 8;
  localparam int CNTW  = 2;
  localparam int SATV  = (1 << CNTW) - 1;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] inData;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outData;
  logic [CNTW-1:0]  stallCnt;

  int errorCount = 0;
  int checkCount = 0;

  logic [WIDTH-1:0] modelQ[$];
  int               stallModel = 0;
  bit               lastInFire = 1'b0;

  pipe_skid #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (inData),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .stall_cnt (stallCnt)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                               input logic r, input logic f);
    inValid  = v;
    inData   = d;
    outReady = r;
    flush    = f;
  endtask

  function automatic int expStall();
`ifdef PIPE_SKID_STALL_CNT_EN
    return stallModel;
`else
    return 0;
`endif
  endfunction

  // Compare DUT outputs with the model, then advance the model by one cycle.
  task automatic stepCycle();
    bit inF;
    bit outF;
    @(negedge clk);
    checkOutput("out_valid", 32'(outValid), 32'(modelQ.size() > 0));
    if (modelQ.size() > 0) checkOutput("out_data", 32'(outData), 32'(modelQ[0]));
    checkOutput("in_ready", 32'(inReady), 32'(modelQ.size() < 2));
    checkOutput("stall_cnt", 32'(stallCnt), 32'(expStall()));
    inF = inValid && (modelQ.size() < 2);
    outF = (modelQ.size() > 0) && outReady;
    if ((modelQ.size() > 0) && !outReady && (stallModel < SATV)) stallModel++;
    if (flush) begin
      modelQ.delete();
    end else begin
      if (outF) void'(modelQ.pop_front());
      if (inF) modelQ.push_back(inData);
    end
    lastInFire = inF;
    @(posedge clk);
    #1;
  endtask

  // Present one payload and hold it until accepted, within a cycle budget.
  task automatic sendHeld(input logic [WIDTH-1:0] d, input logic r);
    int n = 0;
    applyStimulus(1'b1, d, r, 1'b0);
    do begin
      stepCycle();
      n++;
    end while (!lastInFire && n < 20);
    if (!lastInFire) checkOutput("send_timeout", 32'd0, 32'd1);
    applyStimulus(1'b0, '0, r, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic             v;
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_out_data", 32'(outData), 32'd0);
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);
    checkOutput("rst_stall_cnt", 32'(stallCnt), 32'd0);
    reset = 1'b0;

    // Streaming 0x01..0x10 with downstream always ready.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, WIDTH'(i), 1'b1, 1'b0);
      stepCycle();
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    stepCycle();
    stepCycle();

    // Backpressure: two accepts fill the buffer, third payload waits upstream.
    sendHeld(8'hA1, 1'b0);
    sendHeld(8'hA2, 1'b0);
    applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("bp_in_ready_low", 32'(inReady), 32'd0);
    sendHeld(8'hA3, 1'b1);
    for (int i = 0; i < 4; i++) stepCycle();

    // Asynchronous reset while FULL takes effect before the next edge.
    sendHeld(8'h11, 1'b0);
    sendHeld(8'h22, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_out_valid", 32'(outValid), 32'd0);
    checkOutput("async_in_ready", 32'(inReady), 32'd1);
    checkOutput("async_out_data", 32'(outData), 32'd0);
    modelQ.delete();
    stallModel = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    stepCycle();

    // Stall counter: five stalled cycles run the count up into saturation.
    sendHeld(8'h33, 1'b0);
    for (int i = 0; i < 5; i++) stepCycle();

    // Flush from FULL with out_ready: 0x55 delivered, 0x66 dropped, then 0x77.
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    stepCycle();
    sendHeld(8'h55, 1'b0);
    sendHeld(8'h66, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    stepCycle();
    checkOutput("flush_new_accept", 32'(lastInFire), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    stepCycle();
    stepCycle();

    // Random traffic, honouring the upstream hold rule.
    v = 1'b0;
    d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!v || lastInFire) begin
        v = ($urandom_range(0, 3) != 0);
        d = WIDTH'($urandom);
      end
      applyStimulus(v, d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      stepCycle();
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
